// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Bundle between the VGA timing/pixel stage and its neighbours.
//   master : the timing generator. It drives the coordinates, the tick, the
//            DAC colours, the syncs and the strobes. It receives the pixel
//            colour and the display enable.
//   slave  : the frame-buffer reader / pin side. It has the opposite
//            directions.
// Parameters:
//   COLOR_W : bits per colour channel
//   XW, YW  : coordinate widths. These must equal $clog2(H_TOTAL) and
//             $clog2(V_TOTAL) of the attached generator.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if #(
  parameter int COLOR_W = 3,
  parameter int XW      = 10,
  parameter int YW      = 10
);
  logic               check_printting_export;
  logic [COLOR_W-1:0] pixel_r;
  logic [COLOR_W-1:0] pixel_g;
  logic [COLOR_W-1:0] pixel_b;
  logic [XW-1:0]      pixel_x;
  logic [YW-1:0]      pixel_y;
  logic               pixel_tick;
  logic [COLOR_W-1:0] color_r_readdata;
  logic [COLOR_W-1:0] color_g_readdata;
  logic [COLOR_W-1:0] color_b_readdata;
  logic               hsync_writeresponsevalid_n;
  logic               vsync_writeresponsevalid_n;
  logic               printting_writeresponsevalid_n;
  logic               frame_start;
  logic               line_start;

  modport master (
    input  check_printting_export, pixel_r, pixel_g, pixel_b,
    output pixel_x, pixel_y, pixel_tick,
    output color_r_readdata, color_g_readdata, color_b_readdata,
    output hsync_writeresponsevalid_n, vsync_writeresponsevalid_n,
    output printting_writeresponsevalid_n, frame_start, line_start
  );

  modport slave (
    output check_printting_export, pixel_r, pixel_g, pixel_b,
    input  pixel_x, pixel_y, pixel_tick,
    input  color_r_readdata, color_g_readdata, color_b_readdata,
    input  hsync_writeresponsevalid_n, vsync_writeresponsevalid_n,
    input  printting_writeresponsevalid_n, frame_start, line_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA timing generator and pixel-output register. It sits
// between the frame-buffer/sprite reader and the VGA DAC pins.
//
// Ports:
//   clk_clk     : system clock. One pixel lasts CLK_DIV clocks.
//   reset_reset : synchronous, active-high reset.
//   vga         : vga_timing_gen_if.master, carrying:
//     in  check_printting_export : display enable. When 0, colours are 0
//                                  and timing keeps running.
//     in  pixel_r/g/b            : colour for the current (pixel_x, pixel_y)
//     out pixel_x/pixel_y        : live h/v counters, with no latency
//     out pixel_tick             : high in the last clock of each pixel
//     out color_*_readdata       : registered colour to the DAC
//     out hsync/vsync_*_n        : registered syncs (HSYNC_POL/VSYNC_POL)
//     out printting_*_n          : registered active-video flag
//     out frame_start/line_start : one-clock strobes. Each is high in the
//                                  first clock in which the output register
//                                  holds pixel (0,0) or column 0.
//
// The output register is loaded on each tick. The syncs, colours and strobes
// therefore lag pixel_x/pixel_y by one pixel.
//
// Optional build macro VGA_TEST_PATTERN_EN: replaces pixel_r/g/b with eight
// vertical colour bars (bar index = h_cnt*8/H_ACTIVE). Bit 0 of the index
// drives red, bit 1 green and bit 2 blue. Blanking and the enable gating
// still apply.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int COLOR_W   = 3,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CLK_DIV   = 2
) (
  input logic              clk_clk,
  input logic              reset_reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);
  localparam logic [XW-1:0] H_LAST    = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ONE     = XW'(1);
  localparam logic [XW-1:0] H_ACT_END = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEGIN  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END    = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST    = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ONE     = YW'(1);
  localparam logic [YW-1:0] V_ACT_END = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEGIN  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END    = YW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ACT   = (HSYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic VS_ACT   = (VSYNC_POL != 0) ? 1'b1 : 1'b0;
  // The divider resets to 0. That is already the last phase when CLK_DIV is 1.
  localparam logic TICK_RST = (CLK_DIV == 1) ? 1'b1 : 1'b0;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CLK_DIV < 1) begin : g_bad_params
    $fatal(1, "vga_timing_gen: zero active/porch/sync value or CLK_DIV < 1");
  end

  logic [DW-1:0]      div_cnt_q, div_cnt_d;
  logic               tick_q, tick_d;
  logic [XW-1:0]      h_cnt_q, h_cnt_d;
  logic [YW-1:0]      v_cnt_q, v_cnt_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               act_q, act_d;
  logic [COLOR_W-1:0] r_q, r_d;
  logic [COLOR_W-1:0] g_q, g_d;
  logic [COLOR_W-1:0] b_q, b_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;

  logic               active_s;
  logic               hs_on_s;
  logic               vs_on_s;
  logic [COLOR_W-1:0] src_r_s;
  logic [COLOR_W-1:0] src_g_s;
  logic [COLOR_W-1:0] src_b_s;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [XW+2:0] BAR_DIV = (XW+3)'(H_ACTIVE);
  logic [2:0] bar_s;

  // Bar index across the visible width. It is used only while h_cnt < H_ACTIVE.
  always_comb begin
    bar_s   = 3'({h_cnt_q, 3'b000} / BAR_DIV);
    src_r_s = {COLOR_W{bar_s[0]}};
    src_g_s = {COLOR_W{bar_s[1]}};
    src_b_s = {COLOR_W{bar_s[2]}};
  end
`else
  assign src_r_s = vga.pixel_r;
  assign src_g_s = vga.pixel_g;
  assign src_b_s = vga.pixel_b;
`endif

  // Decode the screen region from the live counters.
  always_comb begin
    active_s = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    hs_on_s  = (h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END);
    vs_on_s  = (v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END);
  end

  // Next state for the divider, the pixel counters, the output register and
  // the strobes.
  always_comb begin
    div_cnt_d     = div_cnt_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    act_d         = act_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_ONE;
    end
    // Registering the decode of the next divider value gives the same timing
    // as decoding div_cnt directly.
    tick_d = (div_cnt_d == DIV_LAST);

    if (tick_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + Y_ONE;
        end
      end else begin
        h_cnt_d = h_cnt_q + X_ONE;
      end

      hsync_d = hs_on_s ? HS_ACT : ~HS_ACT;
      vsync_d = vs_on_s ? VS_ACT : ~VS_ACT;
      act_d   = active_s;

      if (active_s && vga.check_printting_export) begin
        r_d = src_r_s;
        g_d = src_g_s;
        b_d = src_b_s;
      end else begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
      end

      // The strobe is high only in the one clock after the loading tick.
      line_start_d  = (h_cnt_q == '0);
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end else begin
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
    end
  end

  // State update with a synchronous active-high reset.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      div_cnt_q     <= '0;
      tick_q        <= TICK_RST;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      act_q         <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      tick_q        <= tick_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      act_q         <= act_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.pixel_x                        = h_cnt_q;
  assign vga.pixel_y                        = v_cnt_q;
  assign vga.pixel_tick                     = tick_q;
  assign vga.color_r_readdata               = r_q;
  assign vga.color_g_readdata               = g_q;
  assign vga.color_b_readdata               = b_q;
  assign vga.hsync_writeresponsevalid_n     = hsync_q;
  assign vga.vsync_writeresponsevalid_n     = vsync_q;
  assign vga.printting_writeresponsevalid_n = act_q;
  assign vga.frame_start                    = frame_start_q;
  assign vga.line_start                     = line_start_q;

endmodule
